// File: rtl/m68k_bus_responder_pkg.sv
// Shared definitions for the 68K bus responder and its chip-select decoder:
// responder state encoding, memory select codes and default wait/timeout values.
package m68k_bus_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_MEM,
        ST_COUNT,
        ST_ACK,
        ST_ERR
    } bus_state_t;

    // Which local region a COUNT wait belongs to; REG_NONE means an unmapped access.
    typedef enum logic [1:0] {
        REG_NONE,
        REG_SHARED,
        REG_IO
    } wait_region_t;

    localparam logic [1:0] MEM_SEL_ROM = 2'd0;
    localparam logic [1:0] MEM_SEL_RAM = 2'd1;

    localparam int DEF_SHARED_WAIT = 1;
    localparam int DEF_IO_WAIT     = 0;
    localparam int DEF_TIMEOUT     = 255;

    localparam int CNT_W = 8;

endpackage

// File: rtl/m68k_bus_responder_bus_wait_counter.sv
// Loadable down-counter with a zero flag; it sticks at zero once reached.
module bus_wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus cycle responder: decodes region selects, runs external memory requests or
// local wait states, and answers the CPU with DTACK or, on timeout, BERR.
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter int SHARED_WAIT = DEF_SHARED_WAIT,
    parameter int IO_WAIT     = DEF_IO_WAIT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [15:0] cpu_dout,
    input  logic        prog_rom_cs,
    input  logic        ram_cs,
    input  logic        shared_ram_cs,
    input  logic        io_cs,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [1:0]  mem_sel,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] shared_rdata,
    input  logic [15:0] io_rdata,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n
);

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SHARED_LOAD  = CNT_W'(SHARED_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD      = CNT_W'(IO_WAIT);

    bus_state_t       state, state_next;
    wait_region_t     wregion, wregion_next;
    logic             as_q;
    logic             rd_q, rd_next;
    logic             stale;
    logic             issue, stale_set;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_value;
    logic             latch_en;
    logic [15:0]      latch_data;

    bus_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .load      (cnt_load),
        .load_value(cnt_value),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_next   = state;
        wregion_next = wregion;
        rd_next      = rd_q;
        issue        = 1'b0;
        stale_set    = 1'b0;
        cnt_load     = 1'b0;
        cnt_value    = '0;
        cnt_dec      = 1'b0;
        latch_en     = 1'b0;
        latch_data   = '0;
        case (state)
            ST_IDLE: begin
                if (as_q && !cpu_as_n) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (cpu_as_n) begin
                    state_next = ST_IDLE;
                end else if (mem_req) begin
                    // An aborted request is still outstanding: wait for its ack, then re-decode.
                    if (!mem_ack) begin
                        state_next = ST_MEM;
                        stale_set  = 1'b1;
                        cnt_load   = 1'b1;
                        cnt_value  = TIMEOUT_LOAD;
                    end
                end else if (prog_rom_cs || ram_cs) begin
                    if (prog_rom_cs && !cpu_rw) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_MEM;
                        issue      = 1'b1;
                        cnt_load   = 1'b1;
                        cnt_value  = TIMEOUT_LOAD;
                    end
                end else begin
                    state_next = ST_COUNT;
                    cnt_load   = 1'b1;
                    rd_next    = cpu_rw;
                    if (shared_ram_cs) begin
                        wregion_next = REG_SHARED;
                        cnt_value    = SHARED_LOAD;
                    end else if (io_cs) begin
                        wregion_next = REG_IO;
                        cnt_value    = IO_LOAD;
                    end else begin
                        wregion_next = REG_NONE;
                        cnt_value    = TIMEOUT_LOAD;
                    end
                end
            end
            ST_MEM: begin
                if (cpu_as_n) begin
                    state_next = ST_IDLE;
                end else if (mem_ack) begin
                    if (stale) begin
                        state_next = ST_DECODE;
                    end else begin
                        state_next = ST_ACK;
                        latch_en   = !mem_we;
                        latch_data = mem_rdata;
                    end
                end else if (cnt_zero) begin
                    state_next = ST_ERR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_COUNT: begin
                if (cpu_as_n) begin
                    state_next = ST_IDLE;
                end else if (cnt_zero) begin
                    if (wregion == REG_NONE) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_ACK;
                        latch_en   = rd_q;
                        latch_data = (wregion == REG_SHARED) ? shared_rdata : io_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACK, ST_ERR: begin
                if (cpu_as_n) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wregion     <= REG_NONE;
            as_q        <= 1'b1;
            rd_q        <= 1'b0;
            stale       <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_sel     <= MEM_SEL_ROM;
            mem_wdata   <= '0;
            cpu_din     <= '0;
            cpu_dtack_n <= 1'b1;
            cpu_berr_n  <= 1'b1;
        end else begin
            state   <= state_next;
            wregion <= wregion_next;
            as_q    <= cpu_as_n;
            rd_q    <= rd_next;
            if (issue) begin
                stale <= 1'b0;
            end else if (stale_set) begin
                stale <= 1'b1;
            end
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= !cpu_rw;
                mem_be    <= {!cpu_uds_n, !cpu_lds_n};
                mem_wdata <= cpu_dout;
                mem_sel   <= prog_rom_cs ? MEM_SEL_ROM : MEM_SEL_RAM;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end
            if (latch_en) cpu_din <= latch_data;
            // Strobes follow the next state so they release in the same cycle AS is seen high.
            cpu_dtack_n <= (state_next != ST_ACK);
            cpu_berr_n  <= (state_next != ST_ERR);
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench for m68k_bus_responder: a driver issues 68K bus cycles and queues the
// expected responses, a memory agent and a strobe monitor pop and compare independently.
module tb_m68k_bus_responder;

    localparam int SW = 1;
    localparam int IW = 0;
    localparam int TO = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
    logic [15:0] cpu_dout;
    logic        prog_rom_cs, ram_cs, shared_ram_cs, io_cs;
    logic        mem_req, mem_we;
    logic [1:0]  mem_be, mem_sel;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata, shared_rdata, io_rdata;
    logic [15:0] cpu_din;
    logic        cpu_dtack_n, cpu_berr_n;

    always #5 clk_sys = ~clk_sys;

    m68k_bus_responder #(
        .SHARED_WAIT(SW),
        .IO_WAIT    (IW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .cpu_as_n     (cpu_as_n),
        .cpu_rw       (cpu_rw),
        .cpu_uds_n    (cpu_uds_n),
        .cpu_lds_n    (cpu_lds_n),
        .cpu_dout     (cpu_dout),
        .prog_rom_cs  (prog_rom_cs),
        .ram_cs       (ram_cs),
        .shared_ram_cs(shared_ram_cs),
        .io_cs        (io_cs),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_sel      (mem_sel),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .shared_rdata (shared_rdata),
        .io_rdata     (io_rdata),
        .cpu_din      (cpu_din),
        .cpu_dtack_n  (cpu_dtack_n),
        .cpu_berr_n   (cpu_berr_n)
    );

    typedef struct {
        bit          is_berr;
        logic [15:0] din;
        int          lat;
        bit          after_stale;
    } resp_t;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [1:0]  sel;
        logic [15:0] wdata;
    } req_t;

    resp_t       resp_q[$];
    req_t        req_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          as_fall_cyc = 0;
    int          mem_delay = 1;
    logic [15:0] mem_data = '0;
    bit          force_ack = 0;
    int          stale_ack_edge = -1;
    bit          track_stale = 0;
    logic [15:0] model_din = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_sys) cyc++;

    // Memory agent: acks each request after mem_delay cycles of mem_req high.
    logic req_prev = 1'b0;
    int   ack_cnt = 0;
    always @(negedge clk_sys) begin
        req_t q;
        mem_ack = 1'b0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            force_ack = 0;
        end else if (mem_req) begin
            if (!req_prev) begin
                ack_cnt = 0;
                if (req_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_mem_req: got request sel=%0d expected none", mem_sel);
                end else begin
                    q = req_q.pop_front();
                    check("mem_request", {mem_we, mem_be, mem_sel, mem_wdata}, {q.we, q.be, q.sel, q.wdata});
                end
            end
            ack_cnt++;
            if (ack_cnt == mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_data;
                if (track_stale) begin
                    stale_ack_edge = cyc + 1;
                    track_stale    = 0;
                end
            end
        end
        req_prev = mem_req;
    end

    // Response monitor: every falling DTACK/BERR consumes one expected response.
    logic dt_prev = 1'b1, be_prev = 1'b1;
    always @(negedge clk_sys) begin
        resp_t r;
        if (reset_n && ((!cpu_dtack_n && dt_prev) || (!cpu_berr_n && be_prev))) begin
            if (resp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_response: got dtack_n=%0b berr_n=%0b expected none", cpu_dtack_n, cpu_berr_n);
            end else begin
                r = resp_q.pop_front();
                check("dtack_n", cpu_dtack_n, r.is_berr);
                check("berr_n", cpu_berr_n, !r.is_berr);
                check("cpu_din", cpu_din, r.din);
                if (r.lat >= 0) check("latency", cyc - as_fall_cyc, r.lat);
                if (r.after_stale) check("after_stale_ack", (stale_ack_edge >= 0) && (cyc > stale_ack_edge), 1);
            end
        end
        dt_prev = cpu_dtack_n;
        be_prev = cpu_berr_n;
    end

    // sels = {rom, ram, shared, io}; strb_n = {uds_n, lds_n}; d = memory ack delay (0 keeps the current one)
    task automatic run_cycle(input logic [3:0] sels, input logic rw, input logic [1:0] strb_n,
                             input logic [15:0] dout, input logic [15:0] rdata, input int d,
                             input int abort_after, input bit after_stale);
        resp_t       r;
        req_t        q;
        logic [15:0] sh_val, io_val, mem_val, new_din;
        bit          needs_mem;
        int          n;
        sh_val    = rdata;
        io_val    = ~rdata;
        mem_val   = rdata ^ 16'h5A5A;
        new_din   = model_din;
        needs_mem = 0;
        r.is_berr = 0;
        r.after_stale = after_stale;
        r.lat     = -1;
        q.we      = !rw;
        q.be      = ~strb_n;
        q.wdata   = dout;
        q.sel     = sels[3] ? 2'd0 : 2'd1;
        if (sels[3] && !rw) begin
            r.lat = 1;
        end else if (sels[3] || sels[2]) begin
            needs_mem = 1;
            r.lat = 1 + d;
            if (rw) new_din = mem_val;
        end else if (sels[1]) begin
            r.lat = 2 + SW;
            if (rw) new_din = sh_val;
        end else if (sels[0]) begin
            r.lat = 2 + IW;
            if (rw) new_din = io_val;
        end else begin
            r.is_berr = 1;
            r.lat = 1 + TO;
        end
        if (after_stale) r.lat = -1;
        if (needs_mem) req_q.push_back(q);
        if (abort_after == 0) begin
            model_din = new_din;
            r.din     = new_din;
            resp_q.push_back(r);
        end

        @(negedge clk_sys);
        {prog_rom_cs, ram_cs, shared_ram_cs, io_cs} = sels;
        cpu_rw       = rw;
        {cpu_uds_n, cpu_lds_n} = strb_n;
        cpu_dout     = dout;
        shared_rdata = sh_val;
        io_rdata     = io_val;
        mem_data     = mem_val;
        if (d > 0) mem_delay = d;
        cpu_as_n     = 1'b0;
        as_fall_cyc  = cyc + 1;
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk_sys);
        end else begin
            n = 0;
            while (cpu_dtack_n && cpu_berr_n && n < 60) begin
                @(negedge clk_sys);
                n++;
            end
            if (n >= 60) begin
                checks++;
                fails++;
                $display("FAIL response_timeout: got no DTACK/BERR in 60 cycles, expected one");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end
        cpu_as_n = 1'b1;
        @(negedge clk_sys);
        {prog_rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        @(negedge clk_sys);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] s;
        reset_n   = 1'b0;
        cpu_as_n  = 1'b1;
        cpu_rw    = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_dout  = '0;
        {prog_rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        shared_rdata = '0;
        io_rdata  = '0;
        repeat (2) @(negedge clk_sys);
        check("reset_values", {mem_req, mem_we, mem_be, mem_sel, mem_wdata, cpu_din, cpu_dtack_n, cpu_berr_n},
              {38'd0, 2'b11});
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // ROM read, ack after 5 cycles with 0x4E71
        run_cycle(4'b1000, 1'b1, 2'b00, 16'h0000, 16'h4E71 ^ 16'h5A5A, 5, 0, 0);
        check("rom_read_din", cpu_din, 16'h4E71);
        // IO read, zero wait
        run_cycle(4'b0001, 1'b1, 2'b00, 16'h0000, ~16'h00A5, 0, 0, 0);
        check("io_read_din", cpu_din, 16'h00A5);
        // Shared byte write, lower strobe only
        run_cycle(4'b0010, 1'b0, 2'b10, 16'hBEEF, 16'h1234, 0, 0, 0);
        // Unmapped access -> bus error
        run_cycle(4'b0000, 1'b1, 2'b00, 16'h0000, 16'h7777, 0, 0, 0);
        // ROM write is ignored without a request
        run_cycle(4'b1000, 1'b0, 2'b00, 16'hCAFE, 16'h0F0F, 0, 0, 0);

        // RAM read aborted in MEM, then an IO read that must wait for the stale ack
        stale_ack_edge = -1;
        track_stale    = 1;
        run_cycle(4'b0100, 1'b1, 2'b00, 16'h0000, 16'hDEAD, 10, 3, 0);
        run_cycle(4'b0001, 1'b1, 2'b00, 16'h0000, 16'h3C3C, 0, 0, 1);
        check("stale_ack_seen", stale_ack_edge >= 0, 1);

        // Reset pulsed while a RAM write waits in MEM
        req_q.push_back('{we: 1'b1, be: 2'b11, sel: 2'd1, wdata: 16'h55AA});
        @(negedge clk_sys);
        ram_cs    = 1'b1;
        cpu_rw    = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        cpu_dout  = 16'h55AA;
        mem_delay = 40;
        cpu_as_n  = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("req_before_reset", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_in_mem", {mem_req, mem_we, mem_be, mem_sel, mem_wdata, cpu_din, cpu_dtack_n, cpu_berr_n},
              {38'd0, 2'b11});
        cpu_as_n = 1'b1;
        ram_cs   = 1'b0;
        model_din = '0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        force_ack = 1;
        repeat (4) @(negedge clk_sys);
        check("late_ack_ignored", {mem_req, cpu_din, cpu_dtack_n, cpu_berr_n}, {1'b0, 16'h0000, 2'b11});

        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom_range(0, 15));
            if (s == 4'b0000 && $urandom_range(0, 2) != 0) s = 4'b0001;
            run_cycle(s, 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(1, 6), 0, 0);
        end

        repeat (4) @(negedge clk_sys);
        check("responses_drained", resp_q.size(), 0);
        check("requests_drained", req_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001 Parameter SHARED_WAIT, default 1: wait cycles before DTACK for shared RAM (0..15).
REQ-002 Parameter IO_WAIT, default 0: wait cycles before DTACK for I/O and video registers (0..15).
REQ-003 Parameter TIMEOUT, default 255: cycles with AS low and no region, or no mem_ack, before a bus error (1..255).
REQ-004 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n  in  1 each  68K bus strobes.
REQ-007 cpu_dout  in  16  68K write data.
REQ-008 prog_rom_cs, ram_cs, shared_ram_cs, io_cs  in  1 each  region selects from the chip-select decoder.
REQ-009 mem_req  out  1  external memory request, held until mem_ack.
REQ-010 mem_we  out 1; mem_be  out 2; mem_sel  out 2 (0=ROM, 1=work RAM); mem_wdata  out 16.
REQ-011 mem_ack  in  1  one-cycle acknowledge; mem_rdata  in  16  valid with mem_ack.
REQ-012 shared_rdata, io_rdata  in  16  combinational read data of shared RAM and I/O.
REQ-013 cpu_din  out 16  registered read data; cpu_dtack_n  out 1; cpu_berr_n  out 1.

Function
REQ-014 States: IDLE, DECODE, MEM, COUNT, ACK, ERR.
REQ-015 IDLE: a falling edge of cpu_as_n (registered cpu_as_n high in the previous cycle, low now) SHALL go to DECODE.
REQ-016 DECODE: selects are sampled one cycle after AS falls, with priority prog_rom_cs > ram_cs > shared_ram_cs > io_cs.
REQ-017 DECODE with no select active SHALL go to COUNT with the timeout loaded; on expiry go to ERR.
REQ-018 DECODE with ROM/RAM: go to MEM and, in the same cycle, drive mem_req=1 with mem_we=!cpu_rw, mem_be={!uds_n,!lds_n}, mem_wdata=cpu_dout and mem_sel.
REQ-019 A ROM write SHALL issue no request and go directly to ACK (ignored write).
REQ-020 MEM: on mem_ack drop mem_req, latch mem_rdata into cpu_din on reads, and go to ACK; if TIMEOUT cycles pass without mem_ack, go to ERR.
REQ-021 DECODE with shared/IO: load SHARED_WAIT/IO_WAIT into COUNT; at count 0 latch shared_rdata/io_rdata on reads and go to ACK; a wait of 0 SHALL give DTACK two cycles after AS falls.
REQ-022 ACK: hold cpu_dtack_n=0 until cpu_as_n=1, then return to IDLE with cpu_dtack_n=1 in the same cycle.
REQ-023 ERR: hold cpu_berr_n=0 until cpu_as_n=1, then return to IDLE; DTACK and BERR SHALL never both be low.
REQ-024 Abort: cpu_as_n rising in DECODE/COUNT SHALL return to IDLE with no DTACK.
REQ-025 Abort in MEM: mem_req stays high until mem_ack, the data is discarded, no DTACK; a new cycle waits in MEM until that ack.
REQ-026 cpu_din holds its last value outside reads; writes never change cpu_din.
REQ-027 At most one mem_req SHALL be outstanding; mem_req never rises while a prior ack is pending.

Reset
REQ-028 Reset values: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_sel 0, mem_wdata 0, cpu_din 0, cpu_dtack_n 1, cpu_berr_n 1, counters 0, and registered cpu_as_n 1.
REQ-029 Reset during any state SHALL drop mem_req immediately; a late mem_ack after release SHALL be ignored in IDLE.

Structure
REQ-030 The state encoding, mem_sel codes and default wait/timeout constants belong in a shared package used with the chip-select decoder.
REQ-031 One sub-module is natural: bus_wait_counter, a loadable down-counter with a zero flag used for waits and timeout.

Verification
REQ-032 ROM read: AS falls with prog_rom_cs, mem_ack after 5 cycles with data 0x4E71 -> mem_req for 5 cycles, cpu_din=0x4E71, DTACK low until AS rises.
REQ-033 IO read, IO_WAIT=0, io_rdata=0x00A5 -> DTACK low on the second cycle after AS falls, cpu_din=0x00A5.
REQ-034 Shared RAM byte write, lds only, SHARED_WAIT=1 -> no mem_req, DTACK on the third cycle, cpu_din unchanged.
REQ-035 AS low with no select, TIMEOUT=8 -> BERR low after 8 count cycles, DTACK stays high, IDLE after AS rises.
REQ-036 RAM read aborted by AS rising before mem_ack, then a new IO cycle -> no DTACK for the first cycle; the IO cycle is acknowledged only after the stale mem_ack.
REQ-037 reset_n pulsed low in MEM -> mem_req=0 asynchronously, all outputs at reset values, a later mem_ack is ignored.
